uart_wb_bridge: RTL

Parametrised Wishbone slave front-end for the UART register file. It succeeds the fixed 8-bit, zero-wait interface block. It supports an 8- or 32-bit bus with byte-lane select, programmable wait states, error termination for illegal accesses, and cycle abort. Downstream it drives single-cycle read/write strobes with latched address and data into the UART register block. It sits between the system Wishbone bus and the register file, inside the UART top level.

---
 rtl/uart_wb_bridge.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_wb_bridge.sv
// Wishbone slave front-end for the UART register file.
// Accepts 8- or 32-bit Wishbone accesses. Inserts programmable wait states
// and error-terminates illegal accesses. Each legal access becomes a single
// one-cycle read or write strobe into the register block, with the register
// index and write byte latched.
module uart_wb_bridge #(
    parameter int WB_DATA_WIDTH  = 32,  // 8 or 32
    parameter int WB_ADDR_WIDTH  = 5,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int WAIT_STATES    = 1,   // 0..15
    parameter int BIG_ENDIAN     = 0
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [WB_ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [WB_DATA_WIDTH-1:0]   wb_dat_i,
    output logic [WB_DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [WB_DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic                       wb_we_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_cyc_i,
    output logic                       wb_ack_o,
    output logic                       wb_err_o,
    output logic [REG_ADDR_WIDTH-1:0]  reg_adr_o,
    output logic [7:0]                 reg_dat_o,
    input  logic [7:0]                 reg_dat_i,
    output logic                       reg_we_o,
    output logic                       reg_re_o
);

    // Byte lane that carries the 8-bit register value on a wide bus.
    localparam int LANE      = (WB_DATA_WIDTH == 32 && BIG_ENDIAN != 0) ? 3 : 0;
    // A 32-bit bus addresses registers on word boundaries.
    localparam int IDX_SHIFT = (WB_DATA_WIDTH == 32) ? 2 : 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STROBE,
        ST_ACK,
        ST_ERR
    } state_e;

    state_e                      state_q;
    logic [3:0]                  wait_cnt_q;
    logic                        we_q;
    logic [REG_ADDR_WIDTH-1:0]   reg_adr_q;
    logic [7:0]                  reg_dat_q;
    logic                        reg_we_q;
    logic                        reg_re_q;
    logic                        wb_ack_q;
    logic                        wb_err_q;
    logic [WB_DATA_WIDTH-1:0]    wb_dat_q;

    logic [REG_ADDR_WIDTH-1:0]   idx_d;
    logic [7:0]                  lane_byte_d;
    logic                        legal_d;
    logic [WB_DATA_WIDTH-1:0]    rd_data_d;

    // Only one byte lane and one select bit are meaningful; the rest of the
    // bus is folded here so it is visibly consumed.
    logic unused_ok;
    assign unused_ok = ^{wb_sel_i, wb_dat_i};

    // Decode the request presented on the bus: index, write byte, legality.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        idx_d       = REG_ADDR_WIDTH'(wb_adr_i >> IDX_SHIFT);
        lane_byte_d = wb_dat_i[LANE*8 +: 8];
        legal_d     = ((wb_adr_i >> (REG_ADDR_WIDTH + IDX_SHIFT)) == '0);
        if (WB_DATA_WIDTH == 32) begin
            legal_d = legal_d && (wb_adr_i[1:0] == 2'b00) && wb_sel_i[LANE];
        end
        rd_data_d   = WB_DATA_WIDTH'(reg_dat_i) << (LANE * 8);
    end

    // Transaction FSM; every output is registered alongside the state change.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            we_q       <= 1'b0;
            reg_adr_q  <= '0;
            reg_dat_q  <= '0;
            reg_we_q   <= 1'b0;
            reg_re_q   <= 1'b0;
            wb_ack_q   <= 1'b0;
            wb_err_q   <= 1'b0;
            wb_dat_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge values, independent of statement order.
            reg_we_q <= 1'b0;
            reg_re_q <= 1'b0;
            wb_ack_q <= 1'b0;
            wb_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        reg_adr_q <= idx_d;
                        reg_dat_q <= lane_byte_d;
                        we_q      <= wb_we_i;
                        if (!legal_d) begin
                            state_q  <= ST_ERR;
                            wb_err_q <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            state_q  <= ST_STROBE;
                            reg_we_q <= wb_we_i;
                            reg_re_q <= !wb_we_i;
                        end else begin
                            state_q    <= ST_WAIT;
                            wait_cnt_q <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!wb_cyc_i) begin
                        // Master abandoned the cycle before anything was committed.
                        state_q <= ST_IDLE;
                    end else if (wait_cnt_q == 4'd0) begin
                        state_q  <= ST_STROBE;
                        reg_we_q <= we_q;
                        reg_re_q <= !we_q;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                ST_STROBE: begin
                    // Committed: acknowledge even if cyc has dropped meanwhile.
                    state_q  <= ST_ACK;
                    wb_ack_q <= 1'b1;
                    if (!we_q) begin
                        wb_dat_q <= rd_data_d;
                    end
                end
                ST_ACK:  state_q <= ST_IDLE;
                ST_ERR:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wb_dat_o  = wb_dat_q;
    assign wb_ack_o  = wb_ack_q;
    assign wb_err_o  = wb_err_q;
    assign reg_adr_o = reg_adr_q;
    assign reg_dat_o = reg_dat_q;
    assign reg_we_o  = reg_we_q;
    assign reg_re_o  = reg_re_q;

endmodule
